// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, CALL/RET sequencing.
// Optional HAZ_PERF_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int RET_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_RsrcAddress,
  input  logic [ADDR_W-1:0] id_RdstAddress,
  input  logic              id_useRsrc,
  input  logic              id_useRdst,
  input  logic              id_call,
  input  logic              id_ret,
  input  logic              ie_memRead,
  input  logic              ie_WB,
  input  logic [ADDR_W-1:0] ie_RdstAddress,
  input  logic              im_branchTaken,
  output logic              stall_if_id,
  output logic              stall_id_ie,
  output logic              pc_hold,
  output logic              flush_if_id,
  output logic              flush_id_ie,
  output logic              flush_ie_im,
  output logic              fwd_pc_high_call,
  output logic              fwd_pc_low_call,
`ifdef HAZ_PERF_EN
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
  output logic              busy
);

  typedef enum logic [2:0] {
    RUN, CALL_HI, CALL_LO, RET_HI, RET_LO, RET_WT
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(RET_WAIT - 1);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       lu;
  logic       s_if_id, s_id_ie, hold, f_if_id, f_id_ie, f_ie_im, f_hi, f_lo;

  assign lu = ie_memRead & ie_WB &
              ((id_useRsrc & (id_RsrcAddress == ie_RdstAddress)) |
               (id_useRdst & (id_RdstAddress == ie_RdstAddress)));

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    s_if_id    = 1'b0;
    s_id_ie    = 1'b0;
    hold       = 1'b0;
    f_if_id    = 1'b0;
    f_id_ie    = 1'b0;
    f_ie_im    = 1'b0;
    f_hi       = 1'b0;
    f_lo       = 1'b0;
    if (im_branchTaken) begin
      // A taken branch overrides everything and aborts any CALL/RET in flight.
      f_if_id    = 1'b1;
      f_id_ie    = 1'b1;
      f_ie_im    = 1'b1;
      next_state = RUN;
      next_cnt   = 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            s_if_id = 1'b1;
            hold    = 1'b1;
            f_id_ie = 1'b1;
          end else if (id_call) begin
            next_state = CALL_HI;
          end else if (id_ret) begin
            next_state = RET_HI;
          end
        end
        CALL_HI: begin
          f_hi       = 1'b1;
          s_if_id    = 1'b1;
          hold       = 1'b1;
          next_state = CALL_LO;
        end
        CALL_LO: begin
          f_lo       = 1'b1;
          s_if_id    = 1'b1;
          hold       = 1'b1;
          next_state = RUN;
        end
        RET_HI: begin
          s_if_id    = 1'b1;
          hold       = 1'b1;
          next_state = RET_LO;
        end
        RET_LO: begin
          s_if_id    = 1'b1;
          hold       = 1'b1;
          next_state = RET_WT;
          next_cnt   = WAIT_LOAD;
        end
        RET_WT: begin
          s_if_id = 1'b1;
          s_id_ie = 1'b1;
          if (cnt == 4'd0) begin
            f_if_id    = 1'b1;
            next_state = RUN;
          end else begin
            hold     = 1'b1;
            next_cnt = cnt - 4'd1;
          end
        end
        default: begin
          next_state = RUN;
          next_cnt   = 4'd0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign stall_if_id      = rst_n & s_if_id;
  assign stall_id_ie      = rst_n & s_id_ie;
  assign pc_hold          = rst_n & hold;
  assign flush_if_id      = rst_n & f_if_id;
  assign flush_id_ie      = rst_n & f_id_ie;
  assign flush_ie_im      = rst_n & f_ie_im;
  assign fwd_pc_high_call = rst_n & f_hi;
  assign fwd_pc_low_call  = rst_n & f_lo;
  assign busy             = rst_n & (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_hold && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if ((flush_if_id | flush_id_ie | flush_ie_im) && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes expected output vectors, monitor compares.
// Define HAZ_PERF_EN to also check the performance counters (instantiated with a 2-bit width).
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_PERF_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] id_RsrcAddress = '0, id_RdstAddress = '0, ie_RdstAddress = '0;
  logic       id_useRsrc = 0, id_useRdst = 0, id_call = 0, id_ret = 0;
  logic       ie_memRead = 0, ie_WB = 0, im_branchTaken = 0;
  logic       stall_if_id, stall_id_ie, pc_hold, flush_if_id, flush_id_ie, flush_ie_im;
  logic       fwd_pc_high_call, fwd_pc_low_call, busy;
`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipeline_hazard_ctrl #(.ADDR_W(3), .RET_WAIT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_RsrcAddress(id_RsrcAddress), .id_RdstAddress(id_RdstAddress),
    .id_useRsrc(id_useRsrc), .id_useRdst(id_useRdst),
    .id_call(id_call), .id_ret(id_ret),
    .ie_memRead(ie_memRead), .ie_WB(ie_WB), .ie_RdstAddress(ie_RdstAddress),
    .im_branchTaken(im_branchTaken),
    .stall_if_id(stall_if_id), .stall_id_ie(stall_id_ie), .pc_hold(pc_hold),
    .flush_if_id(flush_if_id), .flush_id_ie(flush_id_ie), .flush_ie_im(flush_ie_im),
    .fwd_pc_high_call(fwd_pc_high_call), .fwd_pc_low_call(fwd_pc_low_call),
`ifdef HAZ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Output vector order: stall_if_id stall_id_ie pc_hold flush_if_id flush_id_ie flush_ie_im fwd_hi fwd_lo busy
  localparam logic [8:0] O_NONE = 9'b000000000;
  localparam logic [8:0] O_SIF  = 9'b100000000;
  localparam logic [8:0] O_SIE  = 9'b010000000;
  localparam logic [8:0] O_PH   = 9'b001000000;
  localparam logic [8:0] O_FIF  = 9'b000100000;
  localparam logic [8:0] O_FIE  = 9'b000010000;
  localparam logic [8:0] O_FIM  = 9'b000001000;
  localparam logic [8:0] O_FHI  = 9'b000000100;
  localparam logic [8:0] O_FLO  = 9'b000000010;
  localparam logic [8:0] O_BSY  = 9'b000000001;
  localparam logic [8:0] O_LU   = O_SIF | O_PH | O_FIE;
  localparam logic [8:0] O_BR   = O_FIF | O_FIE | O_FIM;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         total = 0;
  int         bad = 0;

  function automatic logic [8:0] outs();
    return {stall_if_id, stall_id_ie, pc_hold, flush_if_id, flush_id_ie, flush_ie_im,
            fwd_pc_high_call, fwd_pc_low_call, busy};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, outs(), e);
      end
    end
  end

  // Inputs: {rst_n, call, ret, branch, memRead, WB, useRsrc, useRdst}, then addresses.
  task automatic step(input logic [7:0] ctl, input logic [2:0] rs, input logic [2:0] rd,
                      input logic [2:0] ierd, input logic [8:0] e, input string n);
    @(posedge clk);
    #1;
    {rst_n, id_call, id_ret, im_branchTaken, ie_memRead, ie_WB, id_useRsrc, id_useRdst} = ctl;
    id_RsrcAddress = rs;
    id_RdstAddress = rd;
    ie_RdstAddress = ierd;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic idle(input logic [8:0] e, input string n);
    step(8'b1000_0000, 3'd0, 3'd5, 3'd7, e, n);
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
  endtask

`ifdef HAZ_PERF_EN
  task automatic check_perf(input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef, input string n);
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== es || perf_flush_cnt !== ef) begin
      bad++;
      $display("FAIL %s: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               n, perf_stall_cnt, perf_flush_cnt, es, ef);
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    idle(O_NONE, "reset_release");

    // Load-use hazard and its non-hazard variants
    step(8'b1000_1110, 3'd3, 3'd0, 3'd3, O_LU,   "lu_rsrc");
    idle(O_NONE, "lu_one_bubble");
    step(8'b1000_1010, 3'd3, 3'd0, 3'd3, O_NONE, "lu_no_wb");
    step(8'b1000_1100, 3'd3, 3'd0, 3'd3, O_NONE, "lu_no_use");
    step(8'b1000_1101, 3'd1, 3'd3, 3'd3, O_LU,   "lu_rdst");
    step(8'b1000_1111, 3'd2, 3'd4, 3'd3, O_NONE, "lu_addr_miss");
    step(8'b1000_0110, 3'd3, 3'd0, 3'd3, O_NONE, "lu_no_load");

    // CALL sequence
    step(8'b1100_0000, 3'd0, 3'd0, 3'd0, O_NONE, "call_start");
    idle(O_SIF | O_PH | O_FHI | O_BSY, "call_hi");
    idle(O_SIF | O_PH | O_FLO | O_BSY, "call_lo");
    idle(O_NONE, "call_done");

    // Load-use takes priority over call start; call and ret together -> CALL
    step(8'b1100_1110, 3'd3, 3'd0, 3'd3, O_LU,   "call_lu_first");
    idle(O_NONE, "call_lu_not_started");
    step(8'b1110_0000, 3'd0, 3'd0, 3'd0, O_NONE, "call_ret_both");
    idle(O_SIF | O_PH | O_FHI | O_BSY, "both_call_hi");
    idle(O_SIF | O_PH | O_FLO | O_BSY, "both_call_lo");
    idle(O_NONE, "both_done");

    // RET sequence with RET_WAIT=2
    step(8'b1010_0000, 3'd0, 3'd0, 3'd0, O_NONE, "ret_start");
    idle(O_SIF | O_PH | O_BSY, "ret_hi");
    idle(O_SIF | O_PH | O_BSY, "ret_lo");
    idle(O_SIF | O_SIE | O_PH | O_BSY, "ret_wt1");
    idle(O_SIF | O_SIE | O_FIF | O_BSY, "ret_wt_exit");
    idle(O_NONE, "ret_done");

    // Branch aborts CALL_LO, dominates load-use, and aborts RET_WT
    step(8'b1100_0000, 3'd0, 3'd0, 3'd0, O_NONE, "br_call_start");
    idle(O_SIF | O_PH | O_FHI | O_BSY, "br_call_hi");
    step(8'b1001_0000, 3'd0, 3'd0, 3'd0, O_BR | O_BSY, "br_in_call_lo");
    idle(O_NONE, "br_call_run");
    step(8'b1001_1110, 3'd3, 3'd0, 3'd3, O_BR, "br_over_lu");
    step(8'b1010_0000, 3'd0, 3'd0, 3'd0, O_NONE, "br_ret_start");
    idle(O_SIF | O_PH | O_BSY, "br_ret_hi");
    idle(O_SIF | O_PH | O_BSY, "br_ret_lo");
    step(8'b1001_0000, 3'd0, 3'd0, 3'd0, O_BR | O_BSY, "br_in_ret_wt");
    idle(O_NONE, "br_ret_run");

    // Async reset in the middle of CALL_HI, with inputs active
    step(8'b1100_0000, 3'd0, 3'd0, 3'd0, O_NONE, "rst_call_start");
    step(8'b0101_1110, 3'd3, 3'd0, 3'd3, O_NONE, "rst_mid_call_hi");
    idle(O_NONE, "rst_after_release");
    idle(O_NONE, "rst_still_run");
    drain();

`ifdef HAZ_PERF_EN
    step(8'b0000_0000, 3'd0, 3'd0, 3'd0, O_NONE, "perf_reset");
    step(8'b1010_0000, 3'd0, 3'd0, 3'd0, O_NONE, "perf_ret_start");
    idle(O_SIF | O_PH | O_BSY, "perf_ret_hi");
    idle(O_SIF | O_PH | O_BSY, "perf_ret_lo");
    idle(O_SIF | O_SIE | O_PH | O_BSY, "perf_ret_wt1");
    idle(O_SIF | O_SIE | O_FIF | O_BSY, "perf_ret_exit");
    drain();
    check_perf(2'd3, 2'd1, "perf_after_ret");
    step(8'b1000_1110, 3'd3, 3'd0, 3'd3, O_LU, "perf_lu");
    drain();
    check_perf(2'd3, 2'd2, "perf_saturate");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
